// File: rtl/segre_pipeline_tracker.sv
// Scoreboard of in-flight register writers in EX/MEM/WB with load-use stall detection.
// Optional macro SEGRE_TRACKER_PERF_EN enables the saturating load-use stall counter.
module segre_pipeline_tracker #(
    parameter int unsigned REG_SIZE  = 5,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 id_valid_i,
    input  logic                 id_we_i,
    input  logic                 id_is_load_i,
    input  logic [REG_SIZE-1:0]  id_wreg_i,
    input  logic [REG_SIZE-1:0]  src_a_i,
    input  logic [REG_SIZE-1:0]  src_b_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic [REG_SIZE-1:0]  ex_wreg_o,
    output logic [REG_SIZE-1:0]  mem_wreg_o,
    output logic [REG_SIZE-1:0]  wb_wreg_o,
    output logic                 ex_valid_o,
    output logic                 mem_valid_o,
    output logic                 wb_valid_o,
    output logic                 load_use_stall_o,
    output logic [1:0]           inflight_cnt_o,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt_o
);

    // Only EX needs is_load: once a load reaches MEM its result is forwardable.
    logic                ex_valid_q, ex_valid_d;
    logic [REG_SIZE-1:0] ex_wreg_q, ex_wreg_d;
    logic                ex_load_q, ex_load_d;
    logic                mem_valid_q;
    logic [REG_SIZE-1:0] mem_wreg_q;
    logic                wb_valid_q;
    logic [REG_SIZE-1:0] wb_wreg_q;
    logic                load_use;
    logic                issue;

    always_comb begin
        load_use  = id_valid_i && !flush_i && ex_valid_q && ex_load_q &&
                    (ex_wreg_q != '0) &&
                    ((ex_wreg_q == src_a_i) || (ex_wreg_q == src_b_i));
        issue     = id_valid_i && id_we_i && (id_wreg_i != '0) && !flush_i && !load_use;
        ex_valid_d = issue;
        ex_wreg_d  = issue ? id_wreg_i : '0;
        ex_load_d  = issue && id_is_load_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            ex_valid_q  <= 1'b0;
            ex_wreg_q   <= '0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wreg_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_wreg_q   <= '0;
        end else if (!stall_i) begin
            wb_valid_q  <= mem_valid_q;
            wb_wreg_q   <= mem_wreg_q;
            mem_valid_q <= ex_valid_q;
            mem_wreg_q  <= ex_wreg_q;
            ex_valid_q  <= ex_valid_d;
            ex_wreg_q   <= ex_wreg_d;
            ex_load_q   <= ex_load_d;
        end
    end

    assign ex_wreg_o        = ex_valid_q  ? ex_wreg_q  : '0;
    assign mem_wreg_o       = mem_valid_q ? mem_wreg_q : '0;
    assign wb_wreg_o        = wb_valid_q  ? wb_wreg_q  : '0;
    assign ex_valid_o       = ex_valid_q;
    assign mem_valid_o      = mem_valid_q;
    assign wb_valid_o       = wb_valid_q;
    assign load_use_stall_o = load_use;
    assign inflight_cnt_o   = {1'b0, ex_valid_q} + {1'b0, mem_valid_q} + {1'b0, wb_valid_q};

`ifdef SEGRE_TRACKER_PERF_EN
    logic [CNT_WIDTH-1:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            perf_q <= '0;
        end else if (load_use && !stall_i && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_stall_cnt_o = perf_q;
`else
    assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: doc/segre_pipeline_tracker.md
SEGRE_PIPELINE_TRACKER -- requirements
Module: segre_pipeline_tracker

Interface
REQ-001 Parameter: REG_SIZE, default 5 (segre_pkg value), width of a register index.
REQ-002 Parameter: CNT_WIDTH, default 32, width of the stall performance counter.
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rsn_i  input  1  reset, synchronous, active-low.
REQ-005 Port: id_valid_i  input  1  valid instruction in ID, presented for issue.
REQ-006 Port: id_we_i  input  1  ID instruction writes the register file.
REQ-007 Port: id_is_load_i  input  1  ID instruction is a load; result is ready only at end of MEM.
REQ-008 Port: id_wreg_i  input  REG_SIZE  ID destination register.
REQ-009 Port: src_a_i, src_b_i  input  REG_SIZE each  ID source registers.
REQ-010 Port: stall_i  input  1  external back-pressure, for example from memory; freezes all stages.
REQ-011 Port: flush_i  input  1  taken branch or jump resolved in EX; ID instruction is discarded.
REQ-012 Port: ex_wreg_o, mem_wreg_o, wb_wreg_o  output  REG_SIZE each  in-flight destination per stage; 0 when entry invalid.
REQ-013 Port: ex_valid_o, mem_valid_o, wb_valid_o  output  1 each  stage holds a register-writing instruction.
REQ-014 Port: load_use_stall_o  output  1  ID must hold; a bubble is inserted into EX.
REQ-015 Port: inflight_cnt_o  output  2  number of valid stage entries, 0..3.
REQ-016 Port: perf_stall_cnt_o  output  CNT_WIDTH  count of load-use stall cycles.

Function
REQ-017 Three entries, EX/MEM/WB, each holding {valid, wreg, is_load}.
REQ-018 load_use_stall_o is combinational, asserted only if all of the following hold:
- id_valid_i and !flush_i;
- EX is valid and EX is_load;
- ex_wreg != 0;
- ex_wreg == src_a_i or ex_wreg == src_b_i.
REQ-019 Issue condition: id_valid_i & id_we_i & (id_wreg_i != 0) & !flush_i & !load_use_stall_o.
REQ-020 Each edge with stall_i=0:
- WB <= MEM;
- MEM <= EX;
- EX <= ID entry if the issue condition holds, else a bubble (valid=0, wreg=0, is_load=0).
REQ-021 Each edge with stall_i=1: all entries hold; stall_i has priority over flush_i and load-use.
REQ-022 flush_i does not affect EX, MEM or WB contents; it only suppresses insertion from ID.
REQ-023 Invalid entries drive wreg output 0, so they never match a non-zero source.
REQ-024 Register x0 is never tracked; id_wreg_i=0 inserts a bubble.
REQ-025 inflight_cnt_o = ex_valid + mem_valid + wb_valid, registered-consistent with the stage state.
- Full: 3, steady back-to-back writers.
- Empty: 0.
REQ-026 Latency: an issued entry is visible on ex_wreg_o the cycle after issue, on mem_wreg_o 2 cycles after, on wb_wreg_o 3 cycles after (absent stall_i).
REQ-027 A load-use stall lasts exactly one cycle when stall_i=0, because the load leaves EX.

Reset
REQ-028 While rsn_i=0 at a clock edge, all entries clear to valid=0, wreg=0, is_load=0, and perf_stall_cnt_o clears to 0.
REQ-029 The first edge after reset: all wreg and valid outputs are 0 and inflight_cnt_o=0.
REQ-030 Reset asserted mid-operation (including during stall_i) discards all in-flight entries in that same edge.

Configuration
REQ-031 Macro SEGRE_TRACKER_PERF_EN.
- Defined: perf_stall_cnt_o increments by 1 on each edge where load_use_stall_o=1 and stall_i=0, saturating at all-ones.
- Undefined: no counter register exists and perf_stall_cnt_o is tied to 0.

Verification
REQ-032 Issue x5 (we=1, non-load) on 3 consecutive unstalled cycles → ex_wreg_o=5 at +1, mem_wreg_o=5 at +2, wb_wreg_o=5 at +3, inflight_cnt_o reaches 3.
REQ-033 Load to x7, then next ID instruction has src_b=7 → load_use_stall_o=1 for one cycle, EX bubble (ex_valid_o=0), then issue proceeds; perf counter=1 with the macro, 0 without.
REQ-034 Load to x0 followed by src_a=0 → load_use_stall_o=0, ex_valid_o=0.
REQ-035 stall_i=1 for 4 cycles with EX/MEM/WB = x3/x2/x1 → outputs hold 3/2/1 and inflight_cnt_o=3 throughout; perf counter unchanged during an overlapping load-use condition.
REQ-036 flush_i=1 with id_valid_i=1, id_wreg_i=9 → next cycle ex_valid_o=0, MEM takes the previous EX entry.
REQ-037 rsn_i=0 for one edge with the pipeline full → all outputs 0 on the next cycle.
